bcd_to_bin: RTL
===============

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameters: none; the block is fixed at 6 BCD digits in and 20 binary bits out.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  conversion request, level-sampled on the rising edge of clk.
REQ-005 bcd_digit_0..bcd_digit_5  input  4 each  BCD digits, 0 = least significant; sampled only when a start is accepted.
REQ-006 bin_out  output  20  binary result, registered, held until the next accepted start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when bin_out/err are updated.
REQ-009 err  output  1  high when the last accepted request contained an invalid digit; held until the next accepted start.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CONV, DONE.
REQ-011 In IDLE with start=1 at edge N, the block SHALL capture all six digits, clear err, and enter CONV with busy=1 from edge N.
REQ-012 CONV SHALL run exactly 20 iterations on edges N+1..N+20, using a 5-bit iteration counter.
REQ-013 Each iteration: shift the {24-bit BCD register, 20-bit result register} right by one; then, for every 4-bit BCD nibble with value >= 8, subtract 3 (reverse double-dabble).
REQ-014 On edge N+20: bin_out <= result, done <= 1, busy <= 0, and the FSM enters DONE.
REQ-015 DONE SHALL last one cycle: done <= 0 and the FSM enters IDLE; done is never high for two consecutive cycles.
REQ-016 While busy=1 or in DONE, start SHALL be ignored; no queuing.
REQ-017 If start stays high through DONE, a new conversion SHALL be accepted on the first IDLE edge, with fresh digit capture.
REQ-018 Result range: 0..999999 (0xF423F); no overflow is possible in 20 bits.
REQ-019 Input digits changing during CONV SHALL NOT affect the result.

Reset
REQ-020 reset_n=0 SHALL immediately force state=IDLE, bin_out=0, busy=0, done=0, err=0, and clear the iteration counter and shift registers.
REQ-021 Reset asserted mid-CONV SHALL abort the conversion with no done pulse; after release, the block accepts a start on the first rising edge.

Configuration
REQ-022 Macro BCD_TO_BIN_CHECK_EN SHALL compile digit-validity checking in or out.
REQ-023 With BCD_TO_BIN_CHECK_EN defined: at acceptance edge N, if any digit > 9, the block skips CONV, sets bin_out <= 0, err <= 1, done <= 1, keeps busy=0, and enters DONE.
REQ-024 Without BCD_TO_BIN_CHECK_EN: err is tied to 0, all requests take the full CONV path, and bin_out for digit codes > 9 is unspecified.

Verification
REQ-025 Digits 000000, start pulse at edge N -> busy high edges N..N+19; done=1 after edge N+20; bin_out=0x00000; err=0.
REQ-026 Digits 999999 -> bin_out=0xF423F; 123456 -> bin_out=0x1E240; 000001 -> bin_out=0x00001.
REQ-027 With CHECK_EN defined: digits 12A456 (digit_3=0xA) -> done=1 after edge N, bin_out=0, err=1, busy never high; a following valid start clears err.
REQ-028 Start 654321, then pulse start again at N+5 with digits 000007 -> second pulse ignored, bin_out=0x9FBF1 after edge N+20; digit change during CONV has no effect.
REQ-029 Start 999999, assert reset_n low at N+10 -> all outputs 0 at once, no done pulse; after release, 000042 converts to 0x0002A.
REQ-030 start held high continuously with 000100 -> back-to-back conversions; done pulses every 22 cycles; bin_out=0x00064 each time.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_if
// Request/result bundle for the bcd_to_bin converter.
//
// Signals:
//   start          conversion request, level-sampled on the rising clock edge
//   bcd_digit_0..5 BCD digits, digit 0 is least significant
//   bin_out        20-bit binary result, held until the next accepted start
//   busy           high while a conversion is running
//   done           one-cycle pulse when bin_out/err are updated
//   err            last accepted request contained a digit above 9
//
// Modports:
//   master  requester side (drives start and digits)
//   slave   converter side (drives the result and status)
// ---------------------------------------------------------------------------
interface bcd_to_bin_if;
    logic        start;
    logic [3:0]  bcd_digit_0;
    logic [3:0]  bcd_digit_1;
    logic [3:0]  bcd_digit_2;
    logic [3:0]  bcd_digit_3;
    logic [3:0]  bcd_digit_4;
    logic [3:0]  bcd_digit_5;
    logic [19:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start,
        output bcd_digit_0, bcd_digit_1, bcd_digit_2,
        output bcd_digit_3, bcd_digit_4, bcd_digit_5,
        input  bin_out, busy, done, err
    );

    modport slave (
        input  start,
        input  bcd_digit_0, bcd_digit_1, bcd_digit_2,
        input  bcd_digit_3, bcd_digit_4, bcd_digit_5,
        output bin_out, busy, done, err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
// Sequential 6-digit BCD to 20-bit binary converter using reverse
// double-dabble: 20 right-shift iterations, each followed by a -3
// correction of every BCD nibble that reads 8 or more.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      bcd_to_bin_if.slave (start, digits in; bin_out, busy, done, err out)
//
// Optional feature: define BCD_TO_BIN_CHECK_EN to enable digit-validity
// checking. A request containing a digit above 9 then skips conversion and
// finishes immediately with bin_out = 0 and err = 1. Without the macro,
// err is constant 0 and every request takes the full conversion path.
//
// Timing: start accepted at edge N, done pulses after edge N+20,
// IDLE again after edge N+21, next start accepted at edge N+22 at earliest.
// ---------------------------------------------------------------------------
module bcd_to_bin (
    input  logic          clk,
    input  logic          reset_n,
    bcd_to_bin_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [23:0] bcd_q;
    logic [19:0] res_q;
    logic [4:0]  iter_q;
    logic [19:0] bin_q;
    logic        busy_q;
    logic        done_q;

    logic [23:0] digits_in;
    logic [23:0] bcd_shift;
    logic [23:0] bcd_next;
    logic [19:0] res_next;
    logic        last_iter;
    logic        digit_bad;

    assign digits_in = {bus.bcd_digit_5, bus.bcd_digit_4, bus.bcd_digit_3,
                        bus.bcd_digit_2, bus.bcd_digit_1, bus.bcd_digit_0};

    assign last_iter = (iter_q == 5'd19);

    // One reverse double-dabble step: shift the concatenated
    // {bcd, result} pair right, then pull every nibble that reads 8 or
    // more back by 3 (a carried-in 1 at nibble bit 3 is worth 8 but should
    // be worth 10/2 = 5).
    always_comb begin
        bcd_shift = {1'b0, bcd_q[23:1]};
        res_next  = {bcd_q[0], res_q[19:1]};
        bcd_next  = bcd_shift;
        for (int i = 0; i < 6; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8) begin
                bcd_next[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_TO_BIN_CHECK_EN
    // Any digit code above 9 marks the whole request invalid.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (digits_in[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end
`else
    assign digit_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Start is only looked at in IDLE, so requests made
    // during CONV or DONE are dropped rather than queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = digit_bad ? DONE : CONV;
                end
            end
            CONV: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and status registers. done defaults low every cycle so it
    // can only ever be a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q  <= '0;
            res_q  <= '0;
            iter_q <= '0;
            bin_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd_q  <= digits_in;
                        res_q  <= '0;
                        iter_q <= '0;
                        if (digit_bad) begin
                            bin_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    bcd_q  <= bcd_next;
                    res_q  <= res_next;
                    iter_q <= iter_q + 5'd1;
                    if (last_iter) begin
                        bin_q  <= res_next;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BCD_TO_BIN_CHECK_EN
    logic err_q;

    // err is refreshed on every accepted request and held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            err_q <= digit_bad;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.bin_out = bin_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
